// File: rtl/ws2812b_pkg.sv
// Shared constants and types for the WS2812b pixel transmitter.
package ws2812b_pkg;

  localparam int unsigned T0H_CYC    = 26;
  localparam int unsigned T1H_CYC    = 51;
  localparam int unsigned TBIT_CYC   = 80;
  localparam int unsigned TLATCH_CYC = 3840;

  localparam int unsigned CNT_W      = 16;
  localparam int unsigned PIXEL_BITS = 24;
  localparam int unsigned BIT_CNT_W  = 5;
  localparam int unsigned ADDR_W     = 4;
  localparam int unsigned DATA_W     = 8;

  localparam logic [ADDR_W-1:0] ADDR_R      = 4'h0;
  localparam logic [ADDR_W-1:0] ADDR_G      = 4'h1;
  localparam logic [ADDR_W-1:0] ADDR_B      = 4'h2;
  localparam logic [ADDR_W-1:0] ADDR_START  = 4'h3;
  localparam logic [ADDR_W-1:0] ADDR_STATUS = 4'h4;

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW,
    LATCH
  } state_t;

  // Wire order of a pixel: G first, MSB first.
  typedef struct packed {
    logic [DATA_W-1:0] g;
    logic [DATA_W-1:0] r;
    logic [DATA_W-1:0] b;
  } pixel_t;

endpackage

// File: rtl/ws2812b_bit_encoder.sv
// NRZ encoder for one WS2812b bit: high phase sized by the bit value, then low to fill the bit period.
module ws2812b_bit_encoder #(
  parameter int unsigned T0H_CYC  = ws2812b_pkg::T0H_CYC,
  parameter int unsigned T1H_CYC  = ws2812b_pkg::T1H_CYC,
  parameter int unsigned TBIT_CYC = ws2812b_pkg::TBIT_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic go,
  input  logic bit_val,
  output logic dout,
  output logic bit_done_c
);
  import ws2812b_pkg::*;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bit_q, bit_d;
  logic             dout_d;

  // Last cycle of the low phase; a go in this cycle starts the next bit with no gap.
  assign bit_done_c = (state_q == LOW) && (cnt_q == CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= 1'b0;
      dout    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      dout    <= dout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    dout_d  = dout;
    case (state_q)
      HIGH: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = LOW;
          dout_d  = 1'b0;
          cnt_d   = bit_q ? CNT_W'(TBIT_CYC - T1H_CYC) : CNT_W'(TBIT_CYC - T0H_CYC);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      LOW: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (go && (state_d == IDLE)) begin
      state_d = HIGH;
      bit_d   = bit_val;
      dout_d  = 1'b1;
      cnt_d   = bit_val ? CNT_W'(T1H_CYC) : CNT_W'(T0H_CYC);
    end
  end

endmodule

// File: rtl/ws2812b_pixel_transmitter.sv
// TinyQV byte peripheral serialising one GRB pixel onto a WS2812b line.
// Optional one-entry pixel queue enabled by defining WS2812B_TX_QUEUE_EN.
module ws2812b_pixel_transmitter #(
  parameter int unsigned T0H_CYC    = ws2812b_pkg::T0H_CYC,
  parameter int unsigned T1H_CYC    = ws2812b_pkg::T1H_CYC,
  parameter int unsigned TBIT_CYC   = ws2812b_pkg::TBIT_CYC,
  parameter int unsigned TLATCH_CYC = ws2812b_pkg::TLATCH_CYC
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [3:0] address,
  input  logic       data_write,
  input  logic [7:0] data_in,
  output logic [7:0] data_out
);
  import ws2812b_pkg::*;

  logic [DATA_W-1:0]     r_q, g_q, b_q;
  state_t                state_q, state_d;
  logic [PIXEL_BITS-1:0] shift_q, shift_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic                  latch_q, latch_d;
  logic [CNT_W-1:0]      lcnt_q, lcnt_d;

  logic   start_c, busy, pending, dout;
  logic   go_c, go_bit_c, bit_done_c, next_c;
  logic   q_valid_c, q_latch_c, q_pop_c;
  pixel_t cur_pix, q_pix_c;
  logic   unused_ui;

  assign unused_ui = ^ui_in;
  assign start_c   = data_write && (address == ADDR_START);
  assign busy      = (state_q != IDLE);
  assign cur_pix   = '{g: g_q, r: r_q, b: b_q};
  assign uo_out    = {8{dout}};

`ifdef WS2812B_TX_QUEUE_EN
  pixel_t q_pix_q;
  logic   q_latch_q, pending_q, q_push_c;

  // A START arriving in the exit cycle is pushed and popped at once, so it chains with no gap.
  assign q_push_c  = start_c && busy && !pending_q;
  assign q_valid_c = pending_q || q_push_c;
  assign q_pix_c   = pending_q ? q_pix_q : cur_pix;
  assign q_latch_c = pending_q ? q_latch_q : data_in[0];
  assign pending   = pending_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= 1'b0;
      q_pix_q   <= '0;
      q_latch_q <= 1'b0;
    end else if (q_pop_c) begin
      pending_q <= 1'b0;
    end else if (q_push_c) begin
      pending_q <= 1'b1;
      q_pix_q   <= cur_pix;
      q_latch_q <= data_in[0];
    end
  end
`else
  logic unused_q_pop;

  assign q_valid_c    = 1'b0;
  assign q_pix_c      = '0;
  assign q_latch_c    = 1'b0;
  assign pending      = 1'b0;
  assign unused_q_pop = q_pop_c;
`endif

  ws2812b_bit_encoder #(
    .T0H_CYC  (T0H_CYC),
    .T1H_CYC  (T1H_CYC),
    .TBIT_CYC (TBIT_CYC)
  ) u_enc (
    .clk        (clk),
    .rst_n      (rst_n),
    .go         (go_c),
    .bit_val    (go_bit_c),
    .dout       (dout),
    .bit_done_c (bit_done_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
      g_q <= '0;
      b_q <= '0;
    end else if (data_write) begin
      case (address)
        ADDR_R:  r_q <= data_in;
        ADDR_G:  g_q <= data_in;
        ADDR_B:  b_q <= data_in;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      latch_q   <= 1'b0;
      lcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      latch_q   <= latch_d;
      lcnt_q    <= lcnt_d;
    end
  end

  // HIGH spans the whole bit here; the encoder splits it into its high and low phases.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    latch_d   = latch_q;
    lcnt_d    = lcnt_q;
    go_c      = 1'b0;
    go_bit_c  = 1'b0;
    q_pop_c   = 1'b0;
    next_c    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_c) begin
          state_d   = HIGH;
          shift_d   = cur_pix;
          latch_d   = data_in[0];
          bit_cnt_d = BIT_CNT_W'(PIXEL_BITS - 1);
          go_c      = 1'b1;
          go_bit_c  = cur_pix.g[DATA_W-1];
        end
      end
      HIGH: begin
        if (bit_done_c) begin
          if (bit_cnt_q != '0) begin
            shift_d   = shift_q << 1;
            bit_cnt_d = bit_cnt_q - BIT_CNT_W'(1);
            go_c      = 1'b1;
            go_bit_c  = shift_q[PIXEL_BITS-2];
          end else if (latch_q) begin
            state_d = LATCH;
            lcnt_d  = CNT_W'(TLATCH_CYC);
          end else begin
            next_c = 1'b1;
          end
        end
      end
      LATCH: begin
        if (lcnt_q == CNT_W'(1)) begin
          next_c = 1'b1;
        end else begin
          lcnt_d = lcnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // Exit decision: chain the queued pixel in the same cycle or fall back to idle.
    if (next_c) begin
      if (q_valid_c) begin
        state_d   = HIGH;
        shift_d   = q_pix_c;
        latch_d   = q_latch_c;
        bit_cnt_d = BIT_CNT_W'(PIXEL_BITS - 1);
        go_c      = 1'b1;
        go_bit_c  = q_pix_c.g[DATA_W-1];
        q_pop_c   = 1'b1;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_comb begin
    data_out = '0;
    case (address)
      ADDR_R:      data_out = r_q;
      ADDR_G:      data_out = g_q;
      ADDR_B:      data_out = b_q;
      ADDR_STATUS: data_out = {6'b0, pending, busy};
      default:     data_out = '0;
    endcase
  end

endmodule

// File: tb/tb_ws2812b_pixel_transmitter.sv
// Randomised bench: a per-cycle waveform model of the line is built from the pixel timing rules.
module tb_ws2812b_pixel_transmitter;

  localparam int T0H    = 26;
  localparam int T1H    = 51;
  localparam int TBIT   = 80;
  localparam int TLATCH = 3840;
`ifdef WS2812B_TX_QUEUE_EN
  localparam bit QUEUE = 1'b1;
`else
  localparam bit QUEUE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uo_out;
  logic [3:0] address = 4'h4;
  logic       data_write = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;

  int total = 0;
  int bad = 0;

  // Expected line level for every upcoming cycle; empty means idle.
  bit         wave[$];
  int         pend_ahead = 0;
  logic [7:0] mr = 8'h00, mg = 8'h00, mb = 8'h00;
  bit         was_busy, was_pend;

  ws2812b_pixel_transmitter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ui_in      (ui_in),
    .uo_out     (uo_out),
    .address    (address),
    .data_write (data_write),
    .data_in    (data_in),
    .data_out   (data_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void push_pixel(input logic [23:0] pix, input bit latch);
    int h;
    for (int i = 23; i >= 0; i--) begin
      h = pix[i] ? T1H : T0H;
      for (int c = 0; c < TBIT; c++) wave.push_back(c < h);
    end
    if (latch) for (int c = 0; c < TLATCH; c++) wave.push_back(1'b0);
  endfunction

  function automatic logic [7:0] model_reg(input logic [3:0] a);
    case (a)
      4'h0:    return mr;
      4'h1:    return mg;
      default: return mb;
    endcase
  endfunction

  // Reference model update on each edge, then compare the line and status after it.
  always @(posedge clk) begin
    if (!rst_n) begin
      wave.delete();
      pend_ahead = 0;
      mr = 8'h00; mg = 8'h00; mb = 8'h00;
    end else begin
      was_busy = (wave.size() != 0);
      was_pend = (pend_ahead != 0);
      if (was_busy) void'(wave.pop_front());
      if (pend_ahead != 0) pend_ahead--;
      if (data_write) begin
        case (address)
          4'h0: mr = data_in;
          4'h1: mg = data_in;
          4'h2: mb = data_in;
          4'h3: begin
            if (!was_busy) push_pixel({mg, mr, mb}, data_in[0]);
            else if (QUEUE && !was_pend) begin
              pend_ahead = wave.size();
              push_pixel({mg, mr, mb}, data_in[0]);
            end
          end
          default: ;
        endcase
      end
    end
    #1;
    chk("dout", {24'h0, uo_out}, (wave.size() != 0 && wave[0]) ? 32'hFF : 32'h00);
    if (address == 4'h4 && !data_write)
      chk("status", {24'h0, data_out}, {30'h0, pend_ahead != 0, wave.size() != 0});
  end

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    address = a; data_in = d; data_write = 1'b1;
    @(negedge clk);
    data_write = 1'b0; address = 4'h4;
  endtask

  task automatic rd(input string tag, input logic [3:0] a, input logic [7:0] exp);
    @(negedge clk);
    address = a;
    #1;
    chk(tag, {24'h0, data_out}, {24'h0, exp});
    address = 4'h4;
  endtask

  task automatic wait_idle();
    int n = 0;
    #1;
    while (data_out[0] !== 1'b0 && n < 20000) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("idle_wait", {31'h0, data_out[0]}, 32'h0);
  endtask

  task automatic load_random();
    wr(4'h0, 8'($urandom));
    wr(4'h1, 8'($urandom));
    wr(4'h2, 8'($urandom));
  endtask

  // Register traffic and occasional extra STARTs while a pixel is in flight.
  task automatic noise(input int cycles, input int max_starts);
    int starts = 0;
    int sel;
    logic [3:0] a;
    for (int i = 0; i < cycles; i++) begin
      sel = $urandom_range(39);
      a = 4'($urandom_range(2));
      if (sel < 3) wr(a, 8'($urandom));
      else if (sel < 6) rd("noise_rd", a, model_reg(a));
      else if (sel == 6 && starts < max_starts) begin
        wr(4'h3, 8'h00);
        starts++;
      end else @(negedge clk);
    end
  endtask

  initial begin
    logic [7:0] v;
    repeat (3) @(negedge clk);
    chk("reset_dout", {24'h0, uo_out}, 32'h0);
    chk("reset_status", {24'h0, data_out}, 32'h0);
    rst_n = 1'b1;
    rd("reset_r", 4'h0, 8'h00);
    rd("reset_g", 4'h1, 8'h00);
    rd("reset_b", 4'h2, 8'h00);
    rd("unmapped", 4'h9, 8'h00);

    // Directed pixel with latch
    wr(4'h1, 8'h80); wr(4'h0, 8'h00); wr(4'h2, 8'h01);
    wr(4'h3, 8'h01);
    rd("t1_g", 4'h1, 8'h80);
    rd("t1_start_rd", 4'h3, 8'h00);
    wait_idle();

    // No latch
    load_random();
    wr(4'h3, 8'h00);
    wait_idle();

    // Queued second pixel, then a third START that must be ignored
    load_random();
    wr(4'h3, 8'h00);
    repeat (90) @(negedge clk);
    load_random();
    wr(4'h3, 8'h00);
    rd("t3_status", 4'h4, QUEUE ? 8'h03 : 8'h01);
    wr(4'h2, 8'($urandom));
    wr(4'h3, 8'h01);
    rd("t4_status", 4'h4, QUEUE ? 8'h03 : 8'h01);
    wait_idle();

    // Register overwrite mid-pixel
    load_random();
    wr(4'h3, 8'h00);
    repeat (200) @(negedge clk);
    v = 8'($urandom);
    wr(4'h0, v);
    rd("t6_r", 4'h0, v);
    wait_idle();

    // Randomised runs
    for (int it = 0; it < 6; it++) begin
      load_random();
      wr(4'h3, ($urandom_range(3) == 0) ? 8'h01 : 8'h00);
      noise($urandom_range(1500, 50), 2);
      wait_idle();
      repeat ($urandom_range(5)) @(negedge clk);
    end

    // Asynchronous reset in the middle of bit 10
    load_random();
    wr(4'h3, 8'h01);
    repeat (830) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_dout", {24'h0, uo_out}, 32'h0);
    chk("rst_status", {24'h0, data_out}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    rd("rst_r", 4'h0, 8'h00);
    rd("rst_g", 4'h1, 8'h00);
    rd("rst_b", 4'h2, 8'h00);
    load_random();
    wr(4'h3, 8'h00);
    wait_idle();
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
